dram_pad_rd_capture: RTL and testbench

Read-side companion to the DRAM pad write-beat logic. It converts double-data-rate read beats, already retimed by the pad into per-cycle pos and neg halves, into 4-beat lines for the DRAM controller. It tracks each issued read command through a programmable read-latency delay line and runs a capture state machine for burst length 4 or 8. It emits an aligned line with a one-cycle valid.

---
 rtl/dram_pad_rd_capture.sv | 154 +++++++++++++++
 tb/tb_dram_pad_rd_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_pad_rd_capture.sv
// rtl/dram_pad_rd_capture.sv - DDR read-beat capture into 4-beat lines
//
// Purpose: tracks each read command through a programmable-latency delay
// line, then captures BL4/BL8 bursts of pad-retimed pos/neg beats and
// emits them as aligned 4-beat lines with a one-cycle valid strobe.
//
// Ports:
//   clk                    core clock, rising edge
//   rst                    synchronous active-high reset
//   dram_io_rd_en          one-cycle read command pulse
//   burst_length_four      1 = BL4, 0 = BL8; sampled with dram_io_rd_en
//   rd_delay               read latency 1..7 cycles (0 acts as 1)
//   pad_rd_data_pos        beat from the rising DQS edge
//   pad_rd_data_neg        beat from the following falling DQS edge
//   io_dram_rd_data        assembled line, beat0 in [DW-1:0]
//   io_dram_rd_data_valid  one-cycle strobe for io_dram_rd_data
//   pad_rd_cnt             capture-cycle counter within the burst
//   rd_overlap_err         sticky overlap error, cleared only by rst
module dram_pad_rd_capture #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dram_io_rd_en,
    input  logic            burst_length_four,
    input  logic [2:0]      rd_delay,
    input  logic [DW-1:0]   pad_rd_data_pos,
    input  logic [DW-1:0]   pad_rd_data_neg,
    output logic [4*DW-1:0] io_dram_rd_data,
    output logic            io_dram_rd_data_valid,
    output logic [1:0]      pad_rd_cnt,
    output logic            rd_overlap_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CAP  = 1'b1
    } state_t;

    logic [6:0]      r_dl_req;
    logic [6:0]      r_dl_bl4;
    state_t          r_state;
    logic [1:0]      r_cnt;
    logic            r_bl4;
    logic [2*DW-1:0] r_slot0;
    logic [4*DW-1:0] r_data;
    logic            r_valid;
    logic            r_err;

    logic [2:0]      w_tap;
    logic            w_start;
    logic            w_start_bl4;
    logic            w_capture;
    logic            w_err_set;
    state_t          w_state_nxt;
    logic [1:0]      w_cnt_nxt;
    logic            w_bl4_nxt;

    // Stage k becomes visible k+1 cycles after the command, so a latency of
    // D cycles is read from stage D-1.
    assign w_tap       = (rd_delay == 3'd0) ? 3'd0 : (rd_delay - 3'd1);
    assign w_start     = r_dl_req[w_tap];
    assign w_start_bl4 = r_dl_bl4[w_tap];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_req <= '0;
            r_dl_bl4 <= '0;
        end else begin
            r_dl_req <= {r_dl_req[5:0], dram_io_rd_en};
            r_dl_bl4 <= {r_dl_bl4[5:0], dram_io_rd_en & burst_length_four};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_bl4   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bl4   <= w_bl4_nxt;
        end
    end

    // r_cnt is always 0 in IDLE, so the start cycle is capture cycle 0
    // without a separate count path.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bl4_nxt   = r_bl4;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_CAP;
                    w_cnt_nxt   = 2'd1;
                    w_bl4_nxt   = w_start_bl4;
                end
            end
            ST_CAP: begin
                w_capture = 1'b1;
                if ((r_bl4 && r_cnt == 2'd1) || (!r_bl4 && r_cnt == 2'd3)) begin
                    w_cnt_nxt = 2'd0;
                    if (w_start) begin
                        // Seamless back-to-back: next cycle is cycle 0 of the new burst.
                        w_bl4_nxt = w_start_bl4;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                    // A start mid-burst is dropped; only the flag records it.
                    w_err_set = w_start;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Slot 1 is never stored: on an odd cycle the current pair goes straight
    // into the upper half of the line alongside the held slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot0 <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_capture & r_cnt[0];
            if (w_capture && !r_cnt[0]) begin
                r_slot0 <= {pad_rd_data_neg, pad_rd_data_pos};
            end
            if (w_capture && r_cnt[0]) begin
                r_data <= {pad_rd_data_neg, pad_rd_data_pos, r_slot0};
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign io_dram_rd_data       = r_data;
    assign io_dram_rd_data_valid = r_valid;
    assign pad_rd_cnt            = r_cnt;
    assign rd_overlap_err        = r_err;

endmodule

// File: tb/tb_dram_pad_rd_capture.sv
// tb/tb_dram_pad_rd_capture.sv - scoreboard bench for dram_pad_rd_capture
module tb_dram_pad_rd_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        bl4 = 1'b0;
    logic [2:0]  rd_delay = 3'd1;
    logic [15:0] pos = '0;
    logic [15:0] neg = '0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [1:0]  rd_cnt;
    logic        ovl_err;

    dram_pad_rd_capture #(.DW(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .dram_io_rd_en         (rd_en),
        .burst_length_four     (bl4),
        .rd_delay              (rd_delay),
        .pad_rd_data_pos       (pos),
        .pad_rd_data_neg       (neg),
        .io_dram_rd_data       (rd_data),
        .io_dram_rd_data_valid (rd_valid),
        .pad_rd_cnt            (rd_cnt),
        .rd_overlap_err        (ovl_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } line_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] val;
    } probe_t;

    line_t  lq[$];
    probe_t pq[$];
    int     cyc = 0;
    int     base = 0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        line_t       l;
        probe_t      p;
        logic [63:0] act;
        if (rd_valid) begin
            checks++;
            if (lq.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected cyc=%0d actual=%h required=no valid", cyc - base, rd_data);
            end else begin
                l = lq.pop_front();
                if (l.cyc != cyc || l.data != rd_data) begin
                    errors++;
                    $display("FAIL line cyc=%0d actual=%h required=%h at cyc %0d",
                             cyc - base, rd_data, l.data, l.cyc - base);
                end
            end
        end else if (lq.size() > 0 && lq[0].cyc <= cyc) begin
            l = lq.pop_front();
            checks++;
            errors++;
            $display("FAIL line_missing cyc=%0d actual=no valid required=%h", l.cyc - base, l.data);
        end
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            checks++;
            case (p.kind)
                0:       act = rd_data;
                1:       act = {62'd0, rd_cnt};
                2:       act = {63'd0, ovl_err};
                default: act = {63'd0, rd_valid};
            endcase
            if (p.cyc != cyc || act != p.val) begin
                errors++;
                $display("FAIL probe%0d cyc=%0d actual=%h required=%h", p.kind, p.cyc - base, act, p.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        pos   = '0;
        neg   = '0;
    endtask

    task automatic go(input int rel);
        while (cyc - base < rel) step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst  = 1'b0;
        base = cyc;
        pq.push_back('{base, 0, 64'd0});
        pq.push_back('{base, 1, 64'd0});
        pq.push_back('{base, 2, 64'd0});
        pq.push_back('{base, 3, 64'd0});
    endtask

    task automatic exp_line(input int rel, input logic [63:0] d);
        lq.push_back('{base + rel, d});
    endtask

    task automatic exp_probe(input int rel, input int kind, input logic [63:0] v);
        pq.push_back('{base + rel, kind, v});
    endtask

    task automatic beat(input int rel, input logic [15:0] p, input logic [15:0] n);
        go(rel);
        pos = p;
        neg = n;
    endtask

    task automatic cmd(input int rel, input logic b4);
        go(rel);
        rd_en = 1'b1;
        bl4   = b4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // BL4, D=3
        rd_delay = 3'd3;
        do_reset();
        exp_probe(13, 1, 64'd0);
        exp_probe(14, 1, 64'd1);
        exp_line(15, 64'h0004_0003_0002_0001);
        exp_probe(15, 1, 64'd0);
        exp_probe(17, 0, 64'h0004_0003_0002_0001);
        cmd(10, 1'b1);
        beat(13, 16'h0001, 16'h0002);
        beat(14, 16'h0003, 16'h0004);
        go(20);

        // BL8, D=1
        rd_delay = 3'd1;
        do_reset();
        exp_probe(6, 1, 64'd0);
        exp_probe(7, 1, 64'd1);
        exp_line(8, 64'h0013_0012_0011_0010);
        exp_probe(8, 1, 64'd2);
        exp_probe(9, 1, 64'd3);
        exp_line(10, 64'h0017_0016_0015_0014);
        exp_probe(10, 1, 64'd0);
        cmd(5, 1'b0);
        beat(6, 16'h0010, 16'h0011);
        beat(7, 16'h0012, 16'h0013);
        beat(8, 16'h0014, 16'h0015);
        beat(9, 16'h0016, 16'h0017);
        go(16);

        // Back-to-back BL4, D=2
        rd_delay = 3'd2;
        do_reset();
        exp_probe(7, 1, 64'd1);
        exp_line(8, 64'h0023_0022_0021_0020);
        exp_probe(8, 1, 64'd0);
        exp_probe(9, 1, 64'd1);
        exp_line(10, 64'h0027_0026_0025_0024);
        exp_probe(11, 2, 64'd0);
        cmd(4, 1'b1);
        cmd(6, 1'b1);
        beat(6, 16'h0020, 16'h0021);
        beat(7, 16'h0022, 16'h0023);
        beat(8, 16'h0024, 16'h0025);
        beat(9, 16'h0026, 16'h0027);
        go(16);

        // Overlap, BL8, D=2
        do_reset();
        exp_probe(7, 2, 64'd0);
        exp_line(8, 64'h0033_0032_0031_0030);
        exp_probe(8, 2, 64'd1);
        exp_line(10, 64'h0037_0036_0035_0034);
        exp_probe(14, 2, 64'd1);
        cmd(4, 1'b0);
        cmd(5, 1'b0);
        beat(6, 16'h0030, 16'h0031);
        beat(7, 16'h0032, 16'h0033);
        beat(8, 16'h0034, 16'h0035);
        beat(9, 16'h0036, 16'h0037);
        go(18);

        // rd_delay 0 acts as 1
        rd_delay = 3'd0;
        do_reset();
        exp_probe(5, 1, 64'd1);
        exp_line(6, 64'h0043_0042_0041_0040);
        cmd(3, 1'b1);
        beat(4, 16'h0040, 16'h0041);
        beat(5, 16'h0042, 16'h0043);
        go(12);

        // Reset mid-burst, BL8, D=1, then a clean BL4
        rd_delay = 3'd1;
        do_reset();
        exp_probe(8, 0, 64'd0);
        exp_probe(8, 1, 64'd0);
        exp_probe(8, 3, 64'd0);
        exp_probe(10, 0, 64'd0);
        exp_probe(10, 3, 64'd0);
        exp_line(15, 64'h0053_0052_0051_0050);
        cmd(5, 1'b0);
        beat(6, 16'h0060, 16'h0061);
        beat(7, 16'h0062, 16'h0063);
        rst = 1'b1;
        beat(8, 16'h0064, 16'h0065);
        rst = 1'b0;
        beat(9, 16'h0066, 16'h0067);
        cmd(12, 1'b1);
        beat(13, 16'h0050, 16'h0051);
        beat(14, 16'h0052, 16'h0053);
        go(22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
